// File: rtl/register_scoreboard_if.sv
// Decode/retire/flush handshake and zero-fill write port of the issue scoreboard.
// The master drives the pipeline side; the slave is the scoreboard.
interface register_scoreboard_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  decode_valid;
    logic [ADDR_WIDTH-1:0] decode_rs;
    logic [ADDR_WIDTH-1:0] decode_rt;
    logic [ADDR_WIDTH-1:0] decode_rd;
    logic                  decode_writes;
    logic                  retire_valid;
    logic [ADDR_WIDTH-1:0] retire_address;
    logic                  flush;
    logic                  issue;
    logic                  stall;
    logic                  ready;
    logic                  clear_write_enable;
    logic [ADDR_WIDTH-1:0] clear_write_address;
    logic [31:0]           clear_write_value;
    logic                  inflight_any;
    logic                  underflow_error;

    modport master (
        output decode_valid, decode_rs, decode_rt, decode_rd, decode_writes,
        output retire_valid, retire_address, flush,
        input  issue, stall, ready, clear_write_enable, clear_write_address,
        input  clear_write_value, inflight_any, underflow_error
    );

    modport slave (
        input  decode_valid, decode_rs, decode_rt, decode_rd, decode_writes,
        input  retire_valid, retire_address, flush,
        output issue, stall, ready, clear_write_enable, clear_write_address,
        output clear_write_value, inflight_any, underflow_error
    );
endinterface

// File: rtl/register_scoreboard.sv
// Issue scoreboard: zero-fills registers 1..NUM_REGS-1 after reset, then tracks
// pending destination writes and stalls decode on RAW hazards or a full WAW counter.
module register_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 2
) (
    input logic                  clock,
    input logic                  reset,
    register_scoreboard_if.slave sb
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [ADDR_WIDTH:0]    LAST_REG  = (ADDR_WIDTH+1)'(NUM_REGS - 1);

    state_t                  state;
    logic [ADDR_WIDTH:0]     fill_ptr;
    logic [COUNT_WIDTH-1:0]  count [NUM_REGS];
    logic                    clear_we_q;
    logic [ADDR_WIDTH-1:0]   clear_addr_q;
    logic                    ready_q;
    logic                    underflow_q;

    logic hazard;
    logic waw_full;
    logic issue_c;
    logic inflight_c;

    // Decisions use registered counts only, so a same-cycle retire never releases a stall.
    always_comb begin
        hazard   = ((sb.decode_rs != '0) && (count[sb.decode_rs] != '0)) ||
                   ((sb.decode_rt != '0) && (count[sb.decode_rt] != '0));
        waw_full = sb.decode_writes && (sb.decode_rd != '0) &&
                   (count[sb.decode_rd] == COUNT_MAX);
        issue_c  = (state == RUN) && sb.decode_valid && !hazard && !waw_full && !sb.flush;
        inflight_c = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inflight_c = inflight_c | (count[r] != '0);
        end
    end

    assign sb.issue               = issue_c;
    assign sb.stall               = sb.decode_valid && !issue_c;
    assign sb.ready               = ready_q;
    assign sb.clear_write_enable  = clear_we_q;
    assign sb.clear_write_address = clear_addr_q;
    assign sb.clear_write_value   = 32'd0;
    assign sb.inflight_any        = inflight_c;
    assign sb.underflow_error     = underflow_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= CLEAR;
            fill_ptr     <= (ADDR_WIDTH+1)'(1);
            clear_we_q   <= 1'b0;
            clear_addr_q <= '0;
            ready_q      <= 1'b0;
            underflow_q  <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                count[r] <= '0;
            end
        end else begin
            case (state)
                CLEAR: begin
                    if (fill_ptr <= LAST_REG) begin
                        clear_we_q   <= 1'b1;
                        clear_addr_q <= fill_ptr[ADDR_WIDTH-1:0];
                        fill_ptr     <= fill_ptr + 1'b1;
                    end else begin
                        clear_we_q   <= 1'b0;
                        clear_addr_q <= '0;
                        ready_q      <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (sb.flush) begin
                        for (int r = 0; r < NUM_REGS; r++) begin
                            count[r] <= '0;
                        end
                    end else begin
                        // Register 0 is never tracked; simultaneous inc and dec cancel.
                        for (int r = 1; r < NUM_REGS; r++) begin
                            if ((issue_c && sb.decode_writes && (sb.decode_rd == ADDR_WIDTH'(r))) &&
                                !(sb.retire_valid && (sb.retire_address == ADDR_WIDTH'(r)) &&
                                  (count[r] != '0))) begin
                                count[r] <= count[r] + COUNT_WIDTH'(1);
                            end else if (!(issue_c && sb.decode_writes &&
                                           (sb.decode_rd == ADDR_WIDTH'(r))) &&
                                         (sb.retire_valid && (sb.retire_address == ADDR_WIDTH'(r)) &&
                                          (count[r] != '0))) begin
                                count[r] <= count[r] - COUNT_WIDTH'(1);
                            end
                        end
                        if (sb.retire_valid && (sb.retire_address != '0) &&
                            (count[sb.retire_address] == '0)) begin
                            underflow_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: zero-fill, RAW/WAW stalls, underflow,
// flush and mid-fill reset, each step with hand-computed expectations.
module tb_register_scoreboard;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    register_scoreboard_if #(.ADDR_WIDTH(5)) sb_if ();

    register_scoreboard #(
        .NUM_REGS   (32),
        .ADDR_WIDTH (5),
        .COUNT_WIDTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sb   (sb_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic w);
        sb_if.decode_valid  = v;
        sb_if.decode_rs     = rs;
        sb_if.decode_rt     = rt;
        sb_if.decode_rd     = rd;
        sb_if.decode_writes = w;
    endtask

    task automatic retire(input logic v, input logic [4:0] a);
        sb_if.retire_valid   = v;
        sb_if.retire_address = a;
    endtask

    task automatic check_fill(input string tag);
        for (int k = 1; k <= 31; k++) begin
            next_cycle();
            #1;
            check({tag, "_we"}, sb_if.clear_write_enable, 1);
            check({tag, "_addr"}, sb_if.clear_write_address, k);
            check({tag, "_ready"}, sb_if.ready, 0);
            check({tag, "_stall"}, sb_if.stall, sb_if.decode_valid);
            check({tag, "_issue"}, sb_if.issue, 0);
        end
        next_cycle();
        #1;
        check({tag, "_we_done"}, sb_if.clear_write_enable, 0);
        check({tag, "_ready_done"}, sb_if.ready, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        retire(0, 0);
        sb_if.flush = 1'b0;
        #2;
        check("rst_issue", sb_if.issue, 0);
        check("rst_stall", sb_if.stall, 0);
        check("rst_ready", sb_if.ready, 0);
        check("rst_we", sb_if.clear_write_enable, 0);
        check("rst_addr", sb_if.clear_write_address, 0);
        check("rst_value", sb_if.clear_write_value, 0);
        check("rst_inflight", sb_if.inflight_any, 0);
        check("rst_underflow", sb_if.underflow_error, 0);

        // Zero-fill with decode_valid held high: stalled throughout
        drive(1, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_fill("fill");
        drive(0, 0, 0, 0, 0);

        // RAW: r3=r1+r2, then r4=r3+r1 waits for r3 retire
        drive(1, 1, 2, 3, 1);
        #1;
        check("raw_a_issue", sb_if.issue, 1);
        next_cycle();
        drive(1, 3, 1, 4, 1);
        #1;
        check("raw_b_issue", sb_if.issue, 0);
        check("raw_b_stall", sb_if.stall, 1);
        check("raw_b_inflight", sb_if.inflight_any, 1);
        next_cycle();
        retire(1, 3);
        #1;
        check("raw_b_same_retire_stall", sb_if.stall, 1);
        next_cycle();
        retire(0, 0);
        #1;
        check("raw_b_release_issue", sb_if.issue, 1);
        next_cycle();
        drive(1, 1, 2, 5, 1);
        #1;
        check("indep_issue", sb_if.issue, 1);
        check("indep_stall", sb_if.stall, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        retire(1, 4);
        next_cycle();
        retire(1, 5);
        next_cycle();
        retire(0, 0);
        #1;
        check("raw_drain_inflight", sb_if.inflight_any, 0);

        // WAW saturation on r7
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 7, 1);
            #1;
            check("waw_issue", sb_if.issue, 1);
            next_cycle();
        end
        #1;
        check("waw_full_stall", sb_if.stall, 1);
        check("waw_full_issue", sb_if.issue, 0);
        drive(1, 0, 0, 8, 1);
        #1;
        check("waw_r8_issue", sb_if.issue, 1);
        next_cycle();
        drive(1, 0, 0, 7, 1);
        retire(1, 7);
        #1;
        check("waw_retire_same_cycle", sb_if.issue, 0);
        next_cycle();
        retire(0, 0);
        #1;
        check("waw_released_issue", sb_if.issue, 1);
        next_cycle();

        // Same-cycle issue and retire on r9 keeps count at 1
        drive(1, 0, 0, 9, 1);
        #1;
        check("r9_first_issue", sb_if.issue, 1);
        next_cycle();
        retire(1, 9);
        #1;
        check("r9_second_issue", sb_if.issue, 1);
        next_cycle();
        drive(1, 9, 0, 0, 0);
        retire(0, 0);
        #1;
        check("r9_count1_stall", sb_if.stall, 1);
        drive(0, 0, 0, 0, 0);
        retire(1, 9);
        next_cycle();
        retire(0, 0);
        drive(1, 9, 0, 0, 0);
        #1;
        check("r9_count0_issue", sb_if.issue, 1);
        check("r9_no_underflow", sb_if.underflow_error, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        retire(1, 10);
        next_cycle();
        retire(0, 0);
        #1;
        check("underflow_set", sb_if.underflow_error, 1);
        next_cycle();
        next_cycle();
        check("underflow_sticky", sb_if.underflow_error, 1);

        // Flush with r7 (count 3) and r8 (count 1) pending
        check("pre_flush_inflight", sb_if.inflight_any, 1);
        sb_if.flush = 1'b1;
        drive(1, 0, 0, 11, 1);
        retire(1, 8);
        #1;
        check("flush_issue", sb_if.issue, 0);
        check("flush_stall", sb_if.stall, 1);
        next_cycle();
        sb_if.flush = 1'b0;
        retire(0, 0);
        drive(1, 7, 8, 12, 1);
        #1;
        check("post_flush_inflight", sb_if.inflight_any, 0);
        check("post_flush_issue", sb_if.issue, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        #1;
        check("post_flush_r12_inflight", sb_if.inflight_any, 1);

        // Reset in the middle of zero-fill restarts at register 1
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) next_cycle();
        #1;
        check("midfill_addr15", sb_if.clear_write_address, 15);
        reset = 1'b1;
        #1;
        check("async_rst_we", sb_if.clear_write_enable, 0);
        check("async_rst_addr", sb_if.clear_write_address, 0);
        check("async_rst_ready", sb_if.ready, 0);
        check("async_rst_underflow", sb_if.underflow_error, 0);
        check("async_rst_inflight", sb_if.inflight_any, 0);
        next_cycle();
        reset = 1'b0;
        check_fill("refill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
Issue controller for the five-stage integer pipeline. After reset it sequences a zero-fill of general registers 1..31 through a dedicated write port. It then tracks destination registers of in-flight instructions between decode and writeback, and stalls decode on read-after-write hazards. It sits beside the decode stage and is the only block that gates instruction issue into the decode/execution pipeline registers.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked
ADDR_WIDTH, 5, register address width
COUNT_WIDTH, 2, width of the per-register pending counter; saturation value is 2^COUNT_WIDTH-1

Ports:
clock  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
decode_valid  input  1  decode stage holds a valid instruction this cycle
decode_rs  input  ADDR_WIDTH  first source register
decode_rt  input  ADDR_WIDTH  second source register
decode_rd  input  ADDR_WIDTH  destination register
decode_writes  input  1  instruction writes decode_rd
retire_valid  input  1  writeback stage commits a register write this cycle
retire_address  input  ADDR_WIDTH  register written by writeback
flush  input  1  discard all in-flight tracking (pipeline flush)
issue  output  1  instruction in decode advances this cycle
stall  output  1  decode_valid high but issue withheld
ready  output  1  zero-fill complete, scoreboard in RUN
clear_write_enable  output  1  zero-fill write strobe to register file
clear_write_address  output  ADDR_WIDTH  zero-fill target register
clear_write_value  output  32  constant 0
inflight_any  output  1  at least one pending counter non-zero
underflow_error  output  1  sticky: retire seen for register with count 0

Behaviour:
- Reset: state CLEAR, fill pointer = 1, all counters 0, underflow_error 0; outputs issue 0, stall 0, ready 0, clear_write_enable 0, clear_write_address 0, inflight_any 0.
- FSM states: CLEAR, RUN. Reset always returns to CLEAR, including mid-fill, and restarts at register 1.
- CLEAR: registered clear_write_enable=1, clear_write_address=pointer; pointer increments each cycle. First strobe on first clock edge after reset deasserts. Registers 1..31 are written on 31 consecutive cycles (NUM_REGS-1 in general). The cycle after the strobe for register NUM_REGS-1, clear_write_enable drops and the FSM enters RUN with ready=1. Register 0 is never written.
- During CLEAR: issue=0; stall=decode_valid. retire_valid and flush are ignored.
- RUN, combinational:
  - hazard = (rs!=0 && count[rs]!=0) || (rt!=0 && count[rt]!=0).
  - waw_full = decode_writes && rd!=0 && count[rd]==max.
  - issue = decode_valid && !hazard && !waw_full && !flush.
  - stall = decode_valid && !issue.
- Counters use the registered value only. A retire in the same cycle does not release a stall; the instruction issues on the following cycle.
- Counter update per cycle (RUN), register r!=0:
  - +1 if issue && decode_writes && rd==r.
  - -1 if retire_valid && retire_address==r && count[r]!=0.
  - Both in the same cycle: unchanged.
- Retire to a register with count 0: no change; underflow_error set, held until reset.
- Retires or issues to register 0: never counted.
- flush: all counters cleared on the next edge; any issue or retire in that cycle is discarded; issue is forced 0 in the flush cycle.
- inflight_any: OR of all counters (combinational from registered state).
- clear_write_value is always 0.

Test Plan:
- Reset released at cycle 0 -> clear_write_enable high cycles 1..31 with addresses 1..31 in order; ready rises cycle 32; stall=1 for decode_valid held throughout.
- RUN: issue add r3=r1+r2, then next cycle r4=r3+r1 -> second stalls until r3's retire edge, issues the cycle after; independent r5=r1+r2 issues without stall.
- Issue writes to r7 three times without retire -> count 3; fourth write to r7 stalls (waw_full) while a read-free write to r8 issues; one retire of r7 releases it next cycle.
- Same-cycle issue to r9 and retire r9 with count 1 -> count stays 1; retire r10 with count 0 -> underflow_error=1 and stays 1.
- Two pending writes plus flush -> inflight_any=0 next cycle; dependent instruction then issues immediately; issue=0 during the flush cycle.
- Assert reset at cycle 15 of zero-fill -> outputs zero asynchronously; after release, fill restarts at address 1 and completes 31 cycles later.
